// File: rtl/imem_boot_loader.sv
// Boot loader: streams a byte image into instruction memory through the
// cpu's external port, verifies each word, then enables the cpu.
module imem_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] ADDR_STEP = 32'd4,
    parameter int          READ_LAT  = 1,
    parameter int          LEN_W     = 16
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic [7:0]  s_byte,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic        cpu_enable,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_VERIFY,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0] HDR_LAST = 8'(LEN_W / 8 - 1);
    localparam logic [2:0] LAT_LAST = 3'(READ_LAT);

    state_t           state_q;
    state_t           state_d;
    logic [31:0]      addr_q;
    logic [31:0]      word_q;
    logic [31:0]      wdata_q;
    logic [31:0]      word_nxt;
    logic [1:0]       byte_cnt;
    logic [7:0]       hdr_cnt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_nxt;
    logic [LEN_W-1:0] word_cnt;
    logic [2:0]       lat_cnt;
    logic             take;
    logic             hdr_done;
    logic             sample;
    logic             match;
    logic             last_word;

    assign addr_ext  = addr_q;
    assign wdata_ext = wdata_q;
    assign take      = s_valid && s_ready;
    assign hdr_done  = hdr_cnt == HDR_LAST;
    assign sample    = lat_cnt == LAT_LAST;
    assign match     = rdata_ext == wdata_q;
    assign last_word = (word_cnt + 1'b1) == len_q;
    assign word_nxt  = {s_byte, word_q[31:8]};

    // Little-endian header shift: each new byte enters at the top.
    always_comb begin
        len_nxt = len_q >> 8;
        len_nxt[LEN_W-1 -: 8] = s_byte;
    end

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d    = state_q;
        s_ready    = 1'b0;
        wen_ext    = 1'b0;
        ren_ext    = 1'b0;
        cpu_enable = 1'b0;
        busy       = 1'b0;
        err        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LEN;
            end
            S_LEN: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (take && hdr_done)
                    state_d = (len_nxt != '0) ? S_DATA : S_DONE;
            end
            S_DATA: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (take && byte_cnt == 2'd3) state_d = S_WRITE;
            end
            S_WRITE: begin
                wen_ext = 1'b1;
                busy    = 1'b1;
                state_d = S_VERIFY;
            end
            S_VERIFY: begin
                busy    = 1'b1;
                ren_ext = !sample;
                if (sample) begin
                    if (!match)        state_d = S_ERROR;
                    else if (last_word) state_d = S_DONE;
                    else               state_d = S_DATA;
                end
            end
            S_DONE: begin
                cpu_enable = 1'b1;
                if (start) state_d = S_LEN;
            end
            S_ERROR: begin
                err = 1'b1;
                if (start) state_d = S_LEN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: header length, word assembly, address and counters.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            addr_q   <= BASE_ADDR;
            word_q   <= '0;
            wdata_q  <= '0;
            byte_cnt <= '0;
            hdr_cnt  <= '0;
            len_q    <= '0;
            word_cnt <= '0;
            lat_cnt  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        addr_q   <= BASE_ADDR;
                        byte_cnt <= '0;
                        hdr_cnt  <= '0;
                        len_q    <= '0;
                        word_cnt <= '0;
                        lat_cnt  <= '0;
                    end
                end
                S_LEN: begin
                    if (take) begin
                        len_q   <= len_nxt;
                        hdr_cnt <= hdr_cnt + 8'd1;
                    end
                end
                S_DATA: begin
                    if (take) begin
                        word_q   <= word_nxt;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) wdata_q <= word_nxt;
                    end
                end
                S_WRITE: begin
                    lat_cnt <= '0;
                end
                S_VERIFY: begin
                    if (!sample) begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end else if (match && !last_word) begin
                        addr_q   <= addr_q + ADDR_STEP;
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: two instances (read latency 1 and 3)
// with small memory models that echo written words after the read latency.
module tb_imem_boot_loader;

    logic        clk;
    logic        arst_n;
    logic [7:0]  s_byte;
    logic        start_a, s_valid_a, s_ready_a, wen_a, ren_a;
    logic        cpu_en_a, busy_a, err_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        start_b, s_valid_b, s_ready_b, wen_b, ren_b;
    logic        cpu_en_b, busy_b, err_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    int checks = 0;
    int failures = 0;
    int sel = 0;
    int gap = 0;
    logic corrupt = 0;
    logic clr = 0;
    logic both_seen = 0;

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    int          wcnt_a = 0;
    int          wcnt_b = 0;
    int          base_w;
    logic [31:0] pa;
    logic [31:0] pb0, pb1, pb2;

    imem_boot_loader #(.READ_LAT(1)) u_a (
        .clk(clk), .arst_n(arst_n), .start(start_a),
        .s_byte(s_byte), .s_valid(s_valid_a), .s_ready(s_ready_a),
        .addr_ext(addr_a), .wen_ext(wen_a), .ren_ext(ren_a),
        .wdata_ext(wdata_a), .rdata_ext(rdata_a),
        .cpu_enable(cpu_en_a), .busy(busy_a), .err(err_a)
    );

    imem_boot_loader #(.READ_LAT(3)) u_b (
        .clk(clk), .arst_n(arst_n), .start(start_b),
        .s_byte(s_byte), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .addr_ext(addr_b), .wen_ext(wen_b), .ren_ext(ren_b),
        .wdata_ext(wdata_b), .rdata_ext(rdata_b),
        .cpu_enable(cpu_en_b), .busy(busy_b), .err(err_b)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Memory model A: write on wen, 1-cycle read pipe, optional corruption of word 0.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) mem_a[i] <= '0;
        end else if (wen_a) begin
            mem_a[addr_a[5:2]] <= wdata_a;
            wcnt_a <= wcnt_a + 1;
        end
        if (ren_a)
            pa <= mem_a[addr_a[5:2]] ^ ((corrupt && addr_a == 0) ? 32'h1 : 32'h0);
        else
            pa <= 32'hBAD0BAD0;
    end
    assign rdata_a = pa;

    // Memory model B: 3-stage read pipe.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) mem_b[i] <= '0;
        end else if (wen_b) begin
            mem_b[addr_b[5:2]] <= wdata_b;
            wcnt_b <= wcnt_b + 1;
        end
        pb0 <= ren_b ? mem_b[addr_b[5:2]] : 32'hBAD0BAD0;
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign rdata_b = pb2;

    // Watch for simultaneous write and read enables.
    always @(negedge clk) begin
        if ((wen_a && ren_a) || (wen_b && ren_b)) both_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel == 0) s_valid_a = v;
        else          s_valid_b = v;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        s_byte = b;
        set_valid(1'b1);
        while (!((sel == 0) ? s_ready_a : s_ready_b) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
        @(negedge clk);
        set_valid(1'b0);
        if (gap != 0) @(negedge clk);
    endtask

    task automatic pulse_start();
        if (sel == 0) start_a = 1'b1;
        else          start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic clear_mem();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(cpu_en_a || err_a) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("wait_end_timeout", 32'(n < 60), 32'd1);
    endtask

    task automatic send_image();
        logic [7:0] img [10];
        img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34,
                8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 10; i++) send(img[i]);
    endtask

    initial begin
        arst_n = 0;
        s_byte = 0;
        start_a = 0; s_valid_a = 0;
        start_b = 0; s_valid_b = 0;
        repeat (2) @(negedge clk);
        chk("reset_outs_a", {26'd0, s_ready_a, wen_a, ren_a, cpu_en_a, busy_a, err_a}, 32'd0);
        chk("reset_addr_a", addr_a, 32'h0);
        chk("reset_wdata_a", wdata_a, 32'h0);
        chk("reset_outs_b", {26'd0, s_ready_b, wen_b, ren_b, cpu_en_b, busy_b, err_b}, 32'd0);
        arst_n = 1;
        clear_mem();

        // Test 1: two-word load with exact latency on the last word.
        sel = 0; gap = 0;
        base_w = wcnt_a;
        pulse_start();
        chk("t1_busy_ready", {30'd0, busy_a, s_ready_a}, 32'd3);
        send(8'h02); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        chk("t1_write_cycle", {31'd0, wen_a}, 32'd1);
        chk("t1_write_addr", addr_a, 32'h4);
        chk("t1_write_data", wdata_a, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_verify_ren", {30'd0, wen_a, ren_a}, 32'd1);
        @(negedge clk);
        chk("t1_verify_sample", {29'd0, ren_a, busy_a, cpu_en_a}, 32'd2);
        @(negedge clk);
        chk("t1_done", {29'd0, cpu_en_a, busy_a, err_a}, 32'd4);
        chk("t1_mem0", mem_a[0], 32'h12345678);
        chk("t1_mem1", mem_a[1], 32'hDEADBEEF);
        chk("t1_writes", 32'(wcnt_a - base_w), 32'd2);
        chk("t1_addr_hold", addr_a, 32'h4);

        // Test 2: restart from DONE, empty image.
        base_w = wcnt_a;
        pulse_start();
        chk("t2_enable_drop", {30'd0, cpu_en_a, busy_a}, 32'd1);
        chk("t2_addr_reload", addr_a, 32'h0);
        send(8'h00); send(8'h00);
        chk("t2_done", {29'd0, cpu_en_a, busy_a, err_a}, 32'd4);
        chk("t2_no_writes", 32'(wcnt_a - base_w), 32'd0);

        // Test 3: gaps between every byte.
        clear_mem();
        gap = 1;
        base_w = wcnt_a;
        pulse_start();
        send_image();
        wait_end();
        gap = 0;
        chk("t3_mem0", mem_a[0], 32'h12345678);
        chk("t3_mem1", mem_a[1], 32'hDEADBEEF);
        chk("t3_writes", 32'(wcnt_a - base_w), 32'd2);
        chk("t3_done", {30'd0, cpu_en_a, err_a}, 32'd2);

        // Test 4: readback mismatch on word 0.
        clear_mem();
        corrupt = 1;
        base_w = wcnt_a;
        pulse_start();
        send(8'h02); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        wait_end();
        chk("t4_error", {28'd0, err_a, cpu_en_a, busy_a, s_ready_a}, 32'd8);
        chk("t4_one_write", 32'(wcnt_a - base_w), 32'd1);
        corrupt = 0;
        pulse_start();
        chk("t4_err_clear", {30'd0, err_a, busy_a}, 32'd1);

        // Test 5: reset after three data bytes, then full load.
        send(8'h02); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33);
        arst_n = 0;
        #1;
        chk("t5_async_reset", {26'd0, s_ready_a, wen_a, ren_a, cpu_en_a, busy_a, err_a}, 32'd0);
        chk("t5_reset_addr", addr_a, 32'h0);
        @(negedge clk);
        arst_n = 1;
        clear_mem();
        base_w = wcnt_a;
        pulse_start();
        send_image();
        wait_end();
        chk("t5_reload_mem0", mem_a[0], 32'h12345678);
        chk("t5_reload_mem1", mem_a[1], 32'hDEADBEEF);
        chk("t5_reload_done", {30'd0, cpu_en_a, err_a}, 32'd2);

        // Test 6a: start during DATA is ignored.
        clear_mem();
        base_w = wcnt_a;
        pulse_start();
        send(8'h02); send(8'h00); send(8'h78); send(8'h56);
        pulse_start();
        chk("t6_start_ignored", {30'd0, busy_a, s_ready_a}, 32'd3);
        send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        wait_end();
        chk("t6_mem0", mem_a[0], 32'h12345678);
        chk("t6_mem1", mem_a[1], 32'hDEADBEEF);
        chk("t6_writes", 32'(wcnt_a - base_w), 32'd2);

        // Test 6b: READ_LAT=3 instance.
        sel = 1;
        base_w = wcnt_b;
        pulse_start();
        send(8'h02); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        chk("t6b_write", {31'd0, wen_b}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6b_ren", {30'd0, wen_b, ren_b}, 32'd1);
        end
        @(negedge clk);
        chk("t6b_sample", {29'd0, ren_b, busy_b, cpu_en_b}, 32'd2);
        @(negedge clk);
        chk("t6b_done", {29'd0, cpu_en_b, busy_b, err_b}, 32'd4);
        chk("t6b_mem0", mem_b[0], 32'h12345678);
        chk("t6b_mem1", mem_b[1], 32'hDEADBEEF);
        chk("t6b_writes", 32'(wcnt_b - base_w), 32'd2);

        chk("wen_ren_exclusive", {31'd0, both_seen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
